// File: rtl/control_unit_multi.sv
// rtl/control_unit_multi.sv - byte-stream command decoder driving N parallel DSP pipelines
// Fetches opcode and MSB-first operands, raises a held one-hot request, waits for ack/swap, reports status.
module control_unit_multi #(
  parameter int n_pipelines    = 2,
  parameter int n_blocks       = 32,
  parameter int reg_addr_width = 4,
  parameter int instr_width    = 32,
  parameter int data_width     = 16,
  parameter int ack_timeout    = 255
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [7:0]                    i_in_byte,
  input  logic                          i_in_ready,
  output logic                          o_next,
  output logic [$clog2(n_blocks)-1:0]   o_block_target,
  output logic [reg_addr_width-1:0]     o_reg_target,
  output logic [instr_width-1:0]        o_instr_out,
  output logic [data_width-1:0]         o_data_out,
  output logic [n_pipelines-1:0]        o_instr_write,
  output logic [n_pipelines-1:0]        o_reg_write,
  output logic [n_pipelines-1:0]        o_reg_update,
  output logic [n_pipelines-1:0]        o_alloc_sram_delay,
  output logic [n_pipelines-1:0]        o_reset_pipeline,
  input  logic [n_pipelines-1:0]        i_cmd_ack,
  output logic                          o_swap_pipelines,
  input  logic                          i_pipelines_swapping,
  output logic [7:0]                    o_status_byte,
  output logic                          o_status_valid,
  output logic                          o_busy
);

  localparam int BW = $clog2(n_blocks);
  localparam int TW = (ack_timeout < 2) ? 1 : $clog2(ack_timeout);
  localparam logic [TW-1:0] TMO_LAST    = TW'(ack_timeout - 1);
  localparam logic [7:0]    DATA_BYTES  = 8'(data_width / 8);
  localparam logic [7:0]    INSTR_BYTES = 8'(instr_width / 8);
  localparam logic [4:0]    PIPE_LIMIT  = 5'(n_pipelines);

  localparam logic [3:0] OP_WRITE_INSTR = 4'h1;
  localparam logic [3:0] OP_WRITE_REG   = 4'h2;
  localparam logic [3:0] OP_UPDATE_REG  = 4'h3;
  localparam logic [3:0] OP_ALLOC_DELAY = 4'h4;
  localparam logic [3:0] OP_SWAP        = 4'h5;
  localparam logic [3:0] OP_RESET_PIPE  = 4'h6;

  localparam logic [7:0] STS_OK       = 8'h00;
  localparam logic [7:0] STS_BAD_OP   = 8'h01;
  localparam logic [7:0] STS_BAD_PIPE = 8'h02;
  localparam logic [7:0] STS_TIMEOUT  = 8'h03;

  typedef enum logic [3:0] {
    ST_READY, ST_DECODE, ST_GET_BLOCK, ST_GET_REG, ST_GET_DATA,
    ST_GET_INSTR, ST_ISSUE, ST_WAIT_ACK, ST_SWAP_WAIT, ST_REPORT
  } state_t;

  state_t          r_state;
  logic [3:0]      r_op;
  logic [3:0]      r_pipe;
  logic            r_cool;
  logic [7:0]      r_left;
  logic [TW-1:0]   r_tmo;
  logic            r_swap_phase;

  logic                   w_fetch;
  logic                   w_take;
  logic                   w_ack;
  logic                   w_tmo_done;
  logic [n_pipelines-1:0] w_onehot;
  logic [data_width-1:0]  w_data_next;
  logic [instr_width-1:0] w_instr_next;

  assign w_fetch    = r_state inside {ST_READY, ST_GET_BLOCK, ST_GET_REG, ST_GET_DATA, ST_GET_INSTR};
  assign w_take     = w_fetch && i_in_ready && !r_cool;
  assign w_ack      = |(i_cmd_ack & w_onehot);
  assign w_tmo_done = (r_tmo == TMO_LAST);

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < n_pipelines; i++) begin
      w_onehot[i] = (r_pipe == 4'(i));
    end
  end

  // MSB-first shift: the oldest byte falls off the top once the field is full
  generate
    if (data_width > 8) begin : g_data_shift
      assign w_data_next = {o_data_out[data_width-9:0], i_in_byte};
    end else begin : g_data_byte
      assign w_data_next = i_in_byte;
    end
    if (instr_width > 8) begin : g_instr_shift
      assign w_instr_next = {o_instr_out[instr_width-9:0], i_in_byte};
    end else begin : g_instr_byte
      assign w_instr_next = i_in_byte;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state            <= ST_READY;
      r_op               <= '0;
      r_pipe             <= '0;
      r_cool             <= 1'b0;
      r_left             <= '0;
      r_tmo              <= '0;
      r_swap_phase       <= 1'b0;
      o_next             <= 1'b0;
      o_block_target     <= '0;
      o_reg_target       <= '0;
      o_instr_out        <= '0;
      o_data_out         <= '0;
      o_instr_write      <= '0;
      o_reg_write        <= '0;
      o_reg_update       <= '0;
      o_alloc_sram_delay <= '0;
      o_reset_pipeline   <= '0;
      o_swap_pipelines   <= 1'b0;
      o_status_byte      <= '0;
      o_status_valid     <= 1'b0;
      o_busy             <= 1'b0;
    end else begin
      o_next           <= w_take;
      r_cool           <= w_take;
      o_swap_pipelines <= 1'b0;
      o_status_valid   <= 1'b0;

      case (r_state)
        ST_READY: begin
          if (w_take) begin
            r_op    <= i_in_byte[7:4];
            r_pipe  <= i_in_byte[3:0];
            r_state <= ST_DECODE;
            o_busy  <= 1'b1;
          end
        end

        ST_DECODE: begin
          r_tmo        <= '0;
          r_swap_phase <= 1'b0;
          if (r_op == 4'h0 || r_op > OP_RESET_PIPE) begin
            o_status_byte  <= STS_BAD_OP;
            o_status_valid <= 1'b1;
            r_state        <= ST_REPORT;
          end else if (r_op != OP_SWAP && {1'b0, r_pipe} >= PIPE_LIMIT) begin
            o_status_byte  <= STS_BAD_PIPE;
            o_status_valid <= 1'b1;
            r_state        <= ST_REPORT;
          end else begin
            case (r_op)
              OP_WRITE_INSTR, OP_WRITE_REG, OP_UPDATE_REG: r_state <= ST_GET_BLOCK;
              OP_ALLOC_DELAY: begin
                r_left  <= DATA_BYTES;
                r_state <= ST_GET_DATA;
              end
              OP_SWAP: begin
                o_swap_pipelines <= 1'b1;
                r_state          <= ST_SWAP_WAIT;
              end
              default: r_state <= ST_ISSUE;
            endcase
          end
        end

        ST_GET_BLOCK: begin
          if (w_take) begin
            o_block_target <= i_in_byte[BW-1:0];
            if (r_op == OP_WRITE_INSTR) begin
              r_left  <= INSTR_BYTES;
              r_state <= ST_GET_INSTR;
            end else begin
              r_state <= ST_GET_REG;
            end
          end
        end

        ST_GET_REG: begin
          if (w_take) begin
            o_reg_target <= i_in_byte[reg_addr_width-1:0];
            r_left       <= DATA_BYTES;
            r_state      <= ST_GET_DATA;
          end
        end

        ST_GET_DATA: begin
          if (w_take) begin
            o_data_out <= w_data_next;
            r_left     <= r_left - 8'd1;
            if (r_left == 8'd1) r_state <= ST_ISSUE;
          end
        end

        ST_GET_INSTR: begin
          if (w_take) begin
            o_instr_out <= w_instr_next;
            r_left      <= r_left - 8'd1;
            if (r_left == 8'd1) r_state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          r_tmo <= '0;
          case (r_op)
            OP_WRITE_INSTR: o_instr_write      <= w_onehot;
            OP_WRITE_REG:   o_reg_write        <= w_onehot;
            OP_UPDATE_REG:  o_reg_update       <= w_onehot;
            OP_ALLOC_DELAY: o_alloc_sram_delay <= w_onehot;
            default:        o_reset_pipeline   <= w_onehot;
          endcase
          r_state <= ST_WAIT_ACK;
        end

        // ack is checked ahead of the timeout so a coinciding ack still succeeds
        ST_WAIT_ACK: begin
          if (w_ack || w_tmo_done) begin
            o_instr_write      <= '0;
            o_reg_write        <= '0;
            o_reg_update       <= '0;
            o_alloc_sram_delay <= '0;
            o_reset_pipeline   <= '0;
            o_status_byte      <= w_ack ? STS_OK : STS_TIMEOUT;
            o_status_valid     <= 1'b1;
            r_state            <= ST_REPORT;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end

        ST_SWAP_WAIT: begin
          if (!r_swap_phase && i_pipelines_swapping) begin
            r_swap_phase <= 1'b1;
            r_tmo        <= '0;
          end else if (r_swap_phase && !i_pipelines_swapping) begin
            o_status_byte  <= STS_OK;
            o_status_valid <= 1'b1;
            r_state        <= ST_REPORT;
          end else if (w_tmo_done) begin
            o_status_byte  <= STS_TIMEOUT;
            o_status_valid <= 1'b1;
            r_state        <= ST_REPORT;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end

        ST_REPORT: begin
          r_state <= ST_READY;
          o_busy  <= 1'b0;
        end

        default: begin
          r_state <= ST_READY;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
